// File: rtl/fabric_irq_pkg.sv
// Shared constants for the fabric IRQ receiver: register addresses and IRQ id width.
package fabric_irq_pkg;
  localparam logic [1:0] IRQ_PENDING = 2'd0;
  localparam logic [1:0] IRQ_ENABLE  = 2'd1;
  localparam logic [1:0] IRQ_MODE    = 2'd2;
  localparam logic [1:0] IRQ_RAW     = 2'd3;
  localparam int         IRQ_ID_W    = 5;
endpackage

// File: rtl/fabric_irq_ctrl_if.sv
// Register port between the CPU and the fabric IRQ receiver.
// Handshake: reg_we/reg_re are single-cycle strobes with no backpressure; read data
// returns on reg_rdata exactly one cycle after reg_re, qualified by a one-cycle reg_rvalid.
interface fabric_irq_ctrl_if;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;

  modport master (output reg_addr, output reg_wdata, output reg_we, output reg_re,
                  input reg_rdata, input reg_rvalid);
  modport slave  (input reg_addr, input reg_wdata, input reg_we, input reg_re,
                  output reg_rdata, output reg_rvalid);
endinterface

// File: rtl/irq_sync_edge.sv
// Per-line synchroniser chain plus one history flop producing the synchronised level and its rising edge.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic RESET,
  input  logic d,
  output logic s,
  output logic rise
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (RESET) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  // prev clears on reset, so a line already high at reset exit shows up as an edge
  assign s    = chain[SYNC_STAGES-1];
  assign rise = s & ~prev;
endmodule

// File: rtl/fabric_irq_ctrl.sv
// Fabric IRQ receiver: synchronises lines, latches them as edge or level, masks, and
// presents one CPU interrupt plus the lowest active line id through a small register port.
module fabric_irq_ctrl
  import fabric_irq_pkg::*;
#(
  parameter int NUM_IRQ     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic [NUM_IRQ-1:0]   irq_in,
  fabric_irq_ctrl_if.slave     bus,
  output logic                 cpu_irq,
  output logic [IRQ_ID_W-1:0]  irq_id
);
  logic [NUM_IRQ-1:0] s, rise;
  logic [NUM_IRQ-1:0] pending, enable, mode;
  logic [NUM_IRQ-1:0] w1c, pending_nxt, active;
  logic [31:0]        rd_word;
  logic               unused_wdata;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .RESET(RESET),
      .d    (irq_in[g]),
      .s    (s[g]),
      .rise (rise[g])
    );
  end

  assign unused_wdata = ^bus.reg_wdata;

  // Level lines follow s and ignore W1C; edge lines let a new edge beat a same-cycle clear
  always_comb begin
    w1c = '0;
    if (bus.reg_we && bus.reg_addr == IRQ_PENDING) w1c = bus.reg_wdata[NUM_IRQ-1:0];
    pending_nxt = (mode & s) | (~mode & ((pending & ~w1c) | rise));
  end

  always_comb begin
    rd_word = '0;
    case (bus.reg_addr)
      IRQ_PENDING: rd_word[NUM_IRQ-1:0] = pending;
      IRQ_ENABLE:  rd_word[NUM_IRQ-1:0] = enable;
      IRQ_MODE:    rd_word[NUM_IRQ-1:0] = mode;
      default:     rd_word[NUM_IRQ-1:0] = s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      pending        <= '0;
      enable         <= '0;
      mode           <= '0;
      bus.reg_rdata  <= '0;
      bus.reg_rvalid <= 1'b0;
    end else begin
      pending        <= pending_nxt;
      bus.reg_rvalid <= bus.reg_re;
      if (bus.reg_re) bus.reg_rdata <= rd_word;
      if (bus.reg_we && bus.reg_addr == IRQ_ENABLE) enable <= bus.reg_wdata[NUM_IRQ-1:0];
      if (bus.reg_we && bus.reg_addr == IRQ_MODE)   mode   <= bus.reg_wdata[NUM_IRQ-1:0];
    end
  end

  // Scan from the top so the lowest active index is the last one assigned
  always_comb begin
    active  = pending & enable & {NUM_IRQ{~RESET}};
    cpu_irq = |active;
    irq_id  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) irq_id = IRQ_ID_W'(i);
    end
  end
endmodule
